// File: rtl/seq_detect_param.sv
// Parameterised serial pattern detector with overlap control and a saturating match counter.
// A pattern is loaded by strobe; detection runs IDLE -> FILL -> HUNT on valid input bits.
module seq_detect_param #(
  parameter int unsigned PAT_W = 6,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in,
  input  logic             in_valid,
  input  logic             load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             overlap,
  input  logic             clr_cnt,
  output logic             match,
  output logic [CNT_W-1:0] match_cnt,
  output logic             armed
);

  localparam int unsigned        FillW    = $clog2(PAT_W + 1);
  localparam logic [FillW-1:0]   FillFull = FillW'(PAT_W);
  localparam logic [CNT_W-1:0]   CntMax   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StFill = 2'd1,
    StHunt = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [PAT_W-1:0]   pat_q, pat_d;
  logic [PAT_W-1:0]   hist_q, hist_d, hist_shift;
  logic [FillW-1:0]   fill_q, fill_d, fill_inc;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               match_q, armed_q;
  logic               hit;

  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    hist_d     = hist_q;
    fill_d     = fill_q;
    hit        = 1'b0;
    hist_shift = (hist_q << 1) | {{(PAT_W-1){1'b0}}, in};
    // fill saturates at PAT_W once the window is full
    fill_inc   = (fill_q == FillFull) ? fill_q : fill_q + 1'b1;

    if (load) begin
      pat_d   = pat_in;
      hist_d  = '0;
      fill_d  = '0;
      state_d = StFill;
    end else begin
      case (state_q)
        StIdle: ;
        StFill, StHunt: begin
          if (in_valid) begin
            hist_d = hist_shift;
            fill_d = fill_inc;
            if (fill_inc == FillFull) begin
              state_d = StHunt;
              if (hist_shift == pat_q) begin
                hit = 1'b1;
                if (!overlap) begin
                  hist_d  = '0;
                  fill_d  = '0;
                  state_d = StFill;
                end
              end
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end

    cnt_d = cnt_q;
    if (hit) begin
      if (clr_cnt)             cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
      else if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
    end else if (clr_cnt) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      pat_q   <= '0;
      hist_q  <= '0;
      fill_q  <= '0;
      cnt_q   <= '0;
      match_q <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      hist_q  <= hist_d;
      fill_q  <= fill_d;
      cnt_q   <= cnt_d;
      match_q <= hit;
      armed_q <= (state_d == StHunt);
    end
  end

  assign match     = match_q;
  assign match_cnt = cnt_q;
  assign armed     = armed_q;

endmodule

// File: tb/tb_seq_detect_param.sv
// Bench for seq_detect_param: directed scenarios then random traffic, both checked against a
// queue-based model of the detection rules. Two instances share stimulus (CNT_W=8 and CNT_W=2).
module tb_seq_detect_param;

  localparam int unsigned PW = 6;

  logic          clk = 1'b0;
  logic          rst, in_b, in_valid, load, overlap, clr_cnt;
  logic [PW-1:0] pat_in;
  logic          match_a, armed_a, match_b, armed_b;
  logic [7:0]    cnt_a;
  logic [1:0]    cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  bit            m_loaded;
  logic [PW-1:0] m_pat;
  bit            m_q[$];
  bit            m_match;
  bit            m_armed;
  int            m_cnt8, m_cnt2;

  always #5 clk = ~clk;

  seq_detect_param #(.PAT_W(PW), .CNT_W(8)) dut_a (
    .clk(clk), .rst(rst), .in(in_b), .in_valid(in_valid), .load(load), .pat_in(pat_in),
    .overlap(overlap), .clr_cnt(clr_cnt), .match(match_a), .match_cnt(cnt_a), .armed(armed_a)
  );

  seq_detect_param #(.PAT_W(PW), .CNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .in(in_b), .in_valid(in_valid), .load(load), .pat_in(pat_in),
    .overlap(overlap), .clr_cnt(clr_cnt), .match(match_b), .match_cnt(cnt_b), .armed(armed_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Model: keep the last PW valid bits seen since the detector was (re)started.
  task automatic model_step();
    bit            hit;
    logic [PW-1:0] win;
    hit = 1'b0;
    if (rst) begin
      m_loaded = 1'b0;
      m_pat    = '0;
      m_q.delete();
      m_cnt8   = 0;
      m_cnt2   = 0;
    end else begin
      if (load) begin
        m_loaded = 1'b1;
        m_pat    = pat_in;
        m_q.delete();
      end else if (m_loaded && in_valid) begin
        m_q.push_back(in_b);
        if (m_q.size() > PW) void'(m_q.pop_front());
        if (m_q.size() == PW) begin
          win = '0;
          foreach (m_q[i]) win = {win[PW-2:0], m_q[i]};
          hit = (win == m_pat);
          if (hit && !overlap) m_q.delete();
        end
      end
      if (hit) begin
        m_cnt8 = clr_cnt ? 1 : (m_cnt8 < 255 ? m_cnt8 + 1 : 255);
        m_cnt2 = clr_cnt ? 1 : (m_cnt2 < 3 ? m_cnt2 + 1 : 3);
      end else if (clr_cnt) begin
        m_cnt8 = 0;
        m_cnt2 = 0;
      end
    end
    m_match = hit;
    m_armed = m_loaded && (m_q.size() == PW);
  endtask

  task automatic cyc(input logic b, input logic v, input logic ld, input logic ov,
                     input logic clr, input logic r);
    rst = r; in_b = b; in_valid = v; load = ld; overlap = ov; clr_cnt = clr;
    @(posedge clk);
    model_step();
    #1;
    chk("match_a", {31'd0, match_a}, {31'd0, m_match});
    chk("cnt_a", {24'd0, cnt_a}, m_cnt8);
    chk("armed_a", {31'd0, armed_a}, {31'd0, m_armed});
    chk("match_b", {31'd0, match_b}, {31'd0, m_match});
    chk("cnt_b", {30'd0, cnt_b}, m_cnt2);
    chk("armed_b", {31'd0, armed_b}, {31'd0, m_armed});
  endtask

  // Feed n valid bits, MSB of bits first.
  task automatic feed(input logic [31:0] bits, input int n, input logic ov);
    for (int i = n - 1; i >= 0; i--) cyc(bits[i], 1'b1, 1'b0, ov, 1'b0, 1'b0);
  endtask

  initial begin
    int exp_seq[4] = '{2, 3, 3, 3};
    rst = 1'b1; in_b = 1'b0; in_valid = 1'b0; load = 1'b0; overlap = 1'b0; clr_cnt = 1'b0;
    pat_in = '0;

    // Reset with everything else asserted: reset must win
    pat_in = 6'b111111;
    cyc(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("rst_match", {31'd0, match_a}, 32'd0);
    chk("rst_armed", {31'd0, armed_a}, 32'd0);
    chk("rst_cnt", {24'd0, cnt_a}, 32'd0);

    // Basic detection
    pat_in = 6'b101110;
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("load_match", {31'd0, match_a}, 32'd0);
    feed(32'b101110, 6, 1'b1);
    chk("basic_match", {31'd0, match_a}, 32'd1);
    chk("basic_cnt", {24'd0, cnt_a}, 32'd1);
    chk("basic_armed", {31'd0, armed_a}, 32'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("basic_pulse_end", {31'd0, match_a}, 32'd0);

    // Overlapping detection
    pat_in = 6'b101101;
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    feed(32'b101101, 6, 1'b1);
    chk("ovl_hit1", {31'd0, match_a}, 32'd1);
    feed(32'b101, 3, 1'b1);
    chk("ovl_hit2", {31'd0, match_a}, 32'd1);
    chk("ovl_cnt", {24'd0, cnt_a}, 32'd2);

    // Non-overlapping detection
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    feed(32'b101101, 6, 1'b0);
    chk("novl_hit1", {31'd0, match_a}, 32'd1);
    chk("novl_armed", {31'd0, armed_a}, 32'd0);
    feed(32'b101, 3, 1'b0);
    chk("novl_nohit", {31'd0, match_a}, 32'd0);
    chk("novl_cnt", {24'd0, cnt_a}, 32'd1);
    chk("novl_unarmed", {31'd0, armed_a}, 32'd0);

    // Gap of invalid cycles mid-pattern
    pat_in = 6'b101110;
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    feed(32'b10111, 5, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'($urandom), 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("gap_nohit", {31'd0, match_a}, 32'd0);
    feed(32'b0, 1, 1'b1);
    chk("gap_hit", {31'd0, match_a}, 32'd1);

    // Load on the completing bit wins and discards it
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    feed(32'b10111, 5, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("ldwin_match", {31'd0, match_a}, 32'd0);
    chk("ldwin_armed", {31'd0, armed_a}, 32'd0);
    feed(32'b10111, 5, 1'b1);
    chk("ldwin_fill_clear", {31'd0, match_a}, 32'd0);
    feed(32'b0, 1, 1'b1);
    chk("ldwin_rehit", {31'd0, match_a}, 32'd1);

    // Saturation on the 2-bit counter, clear coincident with a hit, reset mid-stream
    pat_in = 6'b101101;
    cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    feed(32'b101101, 6, 1'b1);
    chk("sat_cnt1", {30'd0, cnt_b}, 32'd1);
    for (int k = 0; k < 4; k++) begin
      feed(32'b101, 3, 1'b1);
      chk("sat_cnt", {30'd0, cnt_b}, exp_seq[k]);
    end
    feed(32'b10, 2, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("clrhit_cnt", {30'd0, cnt_b}, 32'd1);
    chk("clrhit_match", {31'd0, match_b}, 32'd1);
    feed(32'b10, 2, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("midrst_cnt", {30'd0, cnt_b}, 32'd0);
    chk("midrst_armed", {31'd0, armed_b}, 32'd0);
    feed(32'b101101, 6, 1'b1);
    chk("midrst_nohit", {31'd0, match_b}, 32'd0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      pat_in = PW'($urandom);
      cyc(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) < 3),
          1'($urandom), ($urandom_range(0, 99) < 3), ($urandom_range(0, 199) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_detect_param.md
SEQ_DETECT_PARAM -- requirements
Module: seq_detect_param

Interface
REQ-001 Parameter PAT_W, default 6: pattern length in bits, legal range 2..32.
REQ-002 Parameter CNT_W, default 8: match-counter width, legal range 1..16.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 in  input  1  serial data bit, sampled only when in_valid=1.
REQ-006 in_valid  input  1  qualifies in for the current cycle.
REQ-007 load  input  1  one-cycle strobe that captures pat_in and restarts detection.
REQ-008 pat_in  input  PAT_W  new pattern; bit PAT_W-1 is the first bit of the sequence in time.
REQ-009 overlap  input  1  1 = overlapping detection, 0 = non-overlapping; sampled every cycle.
REQ-010 clr_cnt  input  1  clears match_cnt.
REQ-011 match  output  1  registered one-cycle pulse per detected pattern.
REQ-012 match_cnt  output  CNT_W  saturating count of detected patterns.
REQ-013 armed  output  1  high when a pattern is loaded and PAT_W valid bits have been collected.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE (no pattern loaded), FILL (collecting bits), HUNT (comparing every valid bit).
REQ-015 IDLE: in/in_valid are ignored; load -> FILL.
REQ-016 FILL: each valid bit shifts into history (left shift, new bit at LSB) and increments fill; fill reaching PAT_W -> HUNT.
REQ-017 HUNT: each valid bit shifts into history; the comparison uses the post-shift history value.
REQ-018 A hit SHALL be declared when fill==PAT_W after the shift and the post-shift history equals pat_reg, all PAT_W bits.
REQ-019 match SHALL be high in the cycle after the hit bit is sampled, for exactly one cycle per hit.
REQ-020 There SHALL be no hit in any cycle with in_valid=0; history, fill and state hold.
REQ-021 overlap=1 on a hit: history and fill are retained, and the FSM stays in HUNT.
REQ-022 overlap=0 on a hit: history and fill are cleared to 0 and the FSM goes to FILL.
REQ-023 load in any state: pat_reg<=pat_in, history<=0, fill<=0, FSM->FILL.
REQ-024 load simultaneous with in_valid: load wins, and that cycle's bit is discarded with no hit.
REQ-025 match SHALL be 0 in the cycle following a load.
REQ-026 match_cnt SHALL increment by 1 on each hit and saturate at 2^CNT_W-1 without wrapping.
REQ-027 clr_cnt SHALL set match_cnt to 0 next cycle.
REQ-028 clr_cnt coincident with a hit: the count becomes 1, and match still pulses.
REQ-029 armed SHALL equal (state==HUNT), registered.
REQ-030 armed SHALL drop in the cycle after a load or a non-overlap hit.
REQ-031 fill SHALL be sized to hold PAT_W and SHALL never exceed PAT_W.
REQ-032 Unreachable FSM encodings SHALL recover to IDLE on the next clock.

Reset
REQ-033 rst=1 at a clock edge SHALL force: state=IDLE, pat_reg=0, history=0, fill=0, match=0, match_cnt=0, armed=0.
REQ-034 rst SHALL take priority over load, in_valid and clr_cnt in the same cycle.
REQ-035 Reset asserted mid-sequence SHALL discard all partial history.
REQ-036 After rst, no match is possible until a new load.

Verification
REQ-037 PAT_W=6: rst, then load pat_in=6'b101110, then serial 1,0,1,1,1,0 with in_valid=1 -> match=1 exactly one cycle after the 6th bit, match_cnt=1, armed=1 from the cycle after the 6th bit.
REQ-038 PAT_W=6, overlap=1, load 6'b101101, stream 101101101 -> match pulses after bits 6 and 9, match_cnt=2.
REQ-039 PAT_W=6, overlap=0, same load and stream -> match only after bit 6, match_cnt=1, armed=0 after bit 6 and not re-armed by bit 9.
REQ-040 Stream 10111 followed by a 3-cycle in_valid=0 gap, then 0 -> match after the final 0.
REQ-041 Load asserted with in_valid=1 on the 6th bit of a matching stream -> no match, armed=0, fill=0.
REQ-042 CNT_W=2, 5 hits -> match_cnt sequence 1,2,3,3,3; clr_cnt with a 6th hit -> match_cnt=1; rst mid-stream -> all outputs 0 and no match until a new load.
